// File: rtl/onehot_bus_arbiter.sv
// onehot_bus_arbiter
//   Five-requester round-robin bus arbiter with a registered one-hot grant
//   and bursts of up to MAX_BURST beats.
//
// Optional feature:
//   ARB_HOLD_TIMEOUT_EN -- when defined, a grant whose beat has been stalled
//   by backpressure for 15 consecutive cycles is force-released and
//   io_timeout pulses. When undefined, grants are held indefinitely and
//   io_timeout is tied low.
//
// Parameters:
//   WIDTH      data width of each requester and of io_out
//   MAX_BURST  maximum beats per grant (1..15)
//
// Ports:
//   clock         rising-edge clock
//   reset         synchronous active-low reset
//   io_req[4:0]   request per requester (bit i = requester i+1)
//   io_in1..5     requester data
//   io_out_ready  downstream accepts a beat
//   io_out_valid  io_out carries a beat
//   io_out        data of the granted requester (0 when idle)
//   io_path[4:0]  registered one-hot grant, 0 when idle
//   io_ack[4:0]   one-cycle pulse for the requester whose beat was accepted
//   io_timeout    one-cycle pulse on forced grant release
module onehot_bus_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       io_req,
  input  logic [WIDTH-1:0] io_in1,
  input  logic [WIDTH-1:0] io_in2,
  input  logic [WIDTH-1:0] io_in3,
  input  logic [WIDTH-1:0] io_in4,
  input  logic [WIDTH-1:0] io_in5,
  input  logic             io_out_ready,
  output logic             io_out_valid,
  output logic [WIDTH-1:0] io_out,
  output logic [4:0]       io_path,
  output logic [4:0]       io_ack,
  output logic             io_timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state, state_nxt;
  logic [4:0] path_nxt;
  logic [3:0] beat_cnt, beat_nxt;
  logic [2:0] last, last_nxt;     // index (0..4) of the last released grant
  logic [4:0] pick_onehot;
  logic [2:0] grant_idx;
  logic       granted_req;
  logic       beat;
  logic       burst_done;

`ifdef ARB_HOLD_TIMEOUT_EN
  logic [3:0] stall_cnt;
`endif

  // Round-robin pick: first requesting index after 'last', wrapping 4 -> 0.
  always_comb begin
    logic [2:0] idx;
    idx         = '0;
    pick_onehot = '0;
    for (int unsigned k = 1; k <= 5; k++) begin
      idx = 3'((32'(last) + k) % 5);
      if (pick_onehot == '0 && io_req[idx]) pick_onehot[idx] = 1'b1;
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (io_path[i]) grant_idx = 3'(i);
    end
  end

  assign granted_req = |(io_req & io_path);
  assign beat        = io_out_valid && io_out_ready;
  assign burst_done  = beat && (beat_cnt == 4'(MAX_BURST - 1));

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      io_path  <= '0;
      beat_cnt <= '0;
      last     <= 3'd4;
    end else begin
      state    <= state_nxt;
      io_path  <= path_nxt;
      beat_cnt <= beat_nxt;
      last     <= last_nxt;
    end
  end

`ifdef ARB_HOLD_TIMEOUT_EN
  // Consecutive stalled-beat cycles; any non-stall cycle (beat, idle,
  // dropped request) or the forced release itself clears it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (io_out_valid && !io_out_ready && !io_timeout) begin
      stall_cnt <= stall_cnt + 4'd1;
    end else begin
      stall_cnt <= '0;
    end
  end
`endif

  // Next-state logic
  always_comb begin
    state_nxt = state;
    path_nxt  = io_path;
    beat_nxt  = beat_cnt;
    last_nxt  = last;
    case (state)
      IDLE: begin
        path_nxt = '0;
        if (|io_req) begin
          state_nxt = BUSY;
          path_nxt  = pick_onehot;
          beat_nxt  = '0;
        end
      end
      BUSY: begin
        if (beat) beat_nxt = beat_cnt + 4'd1;
        if (burst_done || !granted_req || io_timeout) begin
          state_nxt = IDLE;
          path_nxt  = '0;
          last_nxt  = grant_idx;
        end
      end
      default: begin
        state_nxt = IDLE;
        path_nxt  = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    io_out_valid = (state == BUSY) && granted_req;
    io_ack       = (io_out_valid && io_out_ready) ? io_path : '0;
    io_out       = ({WIDTH{io_path[0]}} & io_in1) |
                   ({WIDTH{io_path[1]}} & io_in2) |
                   ({WIDTH{io_path[2]}} & io_in3) |
                   ({WIDTH{io_path[3]}} & io_in4) |
                   ({WIDTH{io_path[4]}} & io_in5);
`ifdef ARB_HOLD_TIMEOUT_EN
    // Fires on the 15th consecutive stalled cycle; release happens at that edge.
    io_timeout   = io_out_valid && !io_out_ready && (stall_cnt == 4'd14);
`else
    io_timeout   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_onehot_bus_arbiter.sv
// Testbench for onehot_bus_arbiter (WIDTH=8, MAX_BURST=4).
// Vector table for single bursts and stalls, then hand-written sequences
// for rotation, request drop, backpressure timeout and mid-burst reset.
module tb_onehot_bus_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] io_req;
  logic [7:0] io_in1, io_in2, io_in3, io_in4, io_in5;
  logic       io_out_ready;
  logic       io_out_valid;
  logic [7:0] io_out;
  logic [4:0] io_path;
  logic [4:0] io_ack;
  logic       io_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  onehot_bus_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clock(clock), .reset(reset), .io_req(io_req),
    .io_in1(io_in1), .io_in2(io_in2), .io_in3(io_in3),
    .io_in4(io_in4), .io_in5(io_in5),
    .io_out_ready(io_out_ready), .io_out_valid(io_out_valid),
    .io_out(io_out), .io_path(io_path), .io_ack(io_ack),
    .io_timeout(io_timeout)
  );

  typedef struct {
    logic       rst_n;
    logic [4:0] req;
    logic       ready;
    logic [4:0] path;
    logic       valid;
    logic [7:0] out;
    logic [4:0] ack;
    logic       tmo;
  } vec_t;

  vec_t tv [16];

  function automatic logic [7:0] data_of(input int g);
    case (g)
      0: return 8'h11;
      1: return 8'h22;
      2: return 8'hA5;
      3: return 8'h44;
      default: return 8'h55;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [4:0] p, input logic v,
                          input logic [7:0] o, input logic [4:0] a, input logic t);
    chk({tag, " path"},    32'(io_path),      32'(p));
    chk({tag, " valid"},   32'(io_out_valid), 32'(v));
    chk({tag, " out"},     32'(io_out),       32'(o));
    chk({tag, " ack"},     32'(io_ack),       32'(a));
    chk({tag, " timeout"}, 32'(io_timeout),   32'(t));
  endtask

  // Inputs change just after a falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic r, input logic [4:0] q, input logic rdy);
    reset        = r;
    io_req       = q;
    io_out_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 5'b0, 1'b0);
    @(negedge clock);
    drive(1'b0, 5'b0, 1'b0);
    @(negedge clock);
  endtask

  initial begin
    io_in1 = 8'h11; io_in2 = 8'h22; io_in3 = 8'hA5; io_in4 = 8'h44; io_in5 = 8'h55;

    //          rst  req       rdy  path      v     out    ack       tmo
    tv[0]  = '{1'b0, 5'b00000, 1'b0, 5'b00000, 1'b0, 8'h00, 5'b00000, 1'b0};
    tv[1]  = '{1'b1, 5'b00100, 1'b1, 5'b00000, 1'b0, 8'h00, 5'b00000, 1'b0};
    tv[2]  = '{1'b1, 5'b00100, 1'b1, 5'b00100, 1'b1, 8'hA5, 5'b00100, 1'b0};
    tv[3]  = '{1'b1, 5'b00100, 1'b1, 5'b00100, 1'b1, 8'hA5, 5'b00100, 1'b0};
    tv[4]  = '{1'b1, 5'b00100, 1'b1, 5'b00100, 1'b1, 8'hA5, 5'b00100, 1'b0};
    tv[5]  = '{1'b1, 5'b00100, 1'b1, 5'b00100, 1'b1, 8'hA5, 5'b00100, 1'b0};
    tv[6]  = '{1'b1, 5'b00000, 1'b1, 5'b00000, 1'b0, 8'h00, 5'b00000, 1'b0};
    tv[7]  = '{1'b1, 5'b00001, 1'b1, 5'b00000, 1'b0, 8'h00, 5'b00000, 1'b0};
    tv[8]  = '{1'b1, 5'b00001, 1'b1, 5'b00001, 1'b1, 8'h11, 5'b00001, 1'b0};
    tv[9]  = '{1'b1, 5'b00001, 1'b0, 5'b00001, 1'b1, 8'h11, 5'b00000, 1'b0};
    tv[10] = '{1'b1, 5'b00001, 1'b0, 5'b00001, 1'b1, 8'h11, 5'b00000, 1'b0};
    tv[11] = '{1'b1, 5'b00001, 1'b1, 5'b00001, 1'b1, 8'h11, 5'b00001, 1'b0};
    tv[12] = '{1'b1, 5'b00001, 1'b1, 5'b00001, 1'b1, 8'h11, 5'b00001, 1'b0};
    tv[13] = '{1'b1, 5'b00001, 1'b0, 5'b00001, 1'b1, 8'h11, 5'b00000, 1'b0};
    tv[14] = '{1'b1, 5'b00001, 1'b1, 5'b00001, 1'b1, 8'h11, 5'b00001, 1'b0};
    tv[15] = '{1'b1, 5'b00000, 1'b1, 5'b00000, 1'b0, 8'h00, 5'b00000, 1'b0};

    do_reset();

    // Single burst to requester 3, then a stalled burst to requester 1.
    for (int i = 0; i < 16; i++) begin
      drive(tv[i].rst_n, tv[i].req, tv[i].ready);
      chk_outs($sformatf("vec%0d", i), tv[i].path, tv[i].valid, tv[i].out,
               tv[i].ack, tv[i].tmo);
      @(negedge clock);
    end

    // Full-request rotation: 1,2,3,4,5,1 with one idle cycle between grants.
    do_reset();
    for (int r = 0; r < 6; r++) begin
      drive(1'b1, 5'b11111, 1'b1);
      chk_outs($sformatf("rot%0d idle", r), 5'b0, 1'b0, 8'h00, 5'b0, 1'b0);
      @(negedge clock);
      for (int b = 0; b < 4; b++) begin
        drive(1'b1, 5'b11111, 1'b1);
        chk_outs($sformatf("rot%0d beat%0d", r, b), 5'(1 << (r % 5)), 1'b1,
                 data_of(r % 5), 5'(1 << (r % 5)), 1'b0);
        @(negedge clock);
      end
    end

    // Requester 2 drops after two beats; requester 3 is next.
    do_reset();
    drive(1'b1, 5'b00110, 1'b1);
    chk_outs("drop idle", 5'b0, 1'b0, 8'h00, 5'b0, 1'b0);
    @(negedge clock);
    for (int b = 0; b < 2; b++) begin
      drive(1'b1, 5'b00110, 1'b1);
      chk_outs($sformatf("drop beat%0d", b), 5'b00010, 1'b1, 8'h22, 5'b00010, 1'b0);
      @(negedge clock);
    end
    drive(1'b1, 5'b00100, 1'b1);
    chk_outs("drop noack", 5'b00010, 1'b0, 8'h22, 5'b0, 1'b0);
    @(negedge clock);
    drive(1'b1, 5'b00100, 1'b1);
    chk_outs("drop release", 5'b0, 1'b0, 8'h00, 5'b0, 1'b0);
    @(negedge clock);
    drive(1'b1, 5'b00100, 1'b1);
    chk_outs("drop next", 5'b00100, 1'b1, 8'hA5, 5'b00100, 1'b0);
    @(negedge clock);

    // Backpressure on requester 1 with requester 2 also waiting.
    do_reset();
    drive(1'b1, 5'b00011, 1'b0);
    chk_outs("bp idle", 5'b0, 1'b0, 8'h00, 5'b0, 1'b0);
    @(negedge clock);
`ifdef ARB_HOLD_TIMEOUT_EN
    for (int k = 1; k <= 15; k++) begin
      drive(1'b1, 5'b00011, 1'b0);
      chk_outs($sformatf("bp stall%0d", k), 5'b00001, 1'b1, 8'h11, 5'b0, 1'(k == 15));
      @(negedge clock);
    end
    drive(1'b1, 5'b00011, 1'b1);
    chk_outs("bp released", 5'b0, 1'b0, 8'h00, 5'b0, 1'b0);
    @(negedge clock);
    drive(1'b1, 5'b00011, 1'b1);
    chk_outs("bp next", 5'b00010, 1'b1, 8'h22, 5'b00010, 1'b0);
    @(negedge clock);
`else
    for (int k = 1; k <= 20; k++) begin
      drive(1'b1, 5'b00011, 1'b0);
      chk_outs($sformatf("bp stall%0d", k), 5'b00001, 1'b1, 8'h11, 5'b0, 1'b0);
      @(negedge clock);
    end
    drive(1'b1, 5'b00011, 1'b1);
    chk_outs("bp held beat", 5'b00001, 1'b1, 8'h11, 5'b00001, 1'b0);
    @(negedge clock);
`endif

    // Reset in the middle of a burst; first grant afterwards is requester 1.
    do_reset();
    drive(1'b1, 5'b00100, 1'b1);
    chk_outs("mrst idle", 5'b0, 1'b0, 8'h00, 5'b0, 1'b0);
    @(negedge clock);
    for (int b = 0; b < 2; b++) begin
      drive(1'b1, 5'b00100, 1'b1);
      chk_outs($sformatf("mrst beat%0d", b), 5'b00100, 1'b1, 8'hA5, 5'b00100, 1'b0);
      @(negedge clock);
    end
    drive(1'b0, 5'b00100, 1'b1);
    @(negedge clock);
    drive(1'b1, 5'b10001, 1'b1);
    chk_outs("mrst after", 5'b0, 1'b0, 8'h00, 5'b0, 1'b0);
    @(negedge clock);
    drive(1'b1, 5'b10001, 1'b1);
    chk_outs("mrst first", 5'b00001, 1'b1, 8'h11, 5'b00001, 1'b0);
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_bus_arbiter.md
ONEHOT_BUS_ARBITER -- requirements
Module: onehot_bus_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width of each requester and of the output bus.
REQ-002 SHALL have parameter MAX_BURST, default 4: maximum beats per grant, legal range 1..15.
REQ-003 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset; reset==0 at a rising edge resets the block.
REQ-005 SHALL have port io_req, input, 5: request per requester, bit i = requester i+1.
REQ-006 SHALL have ports io_in1..io_in5, input, WIDTH each: requester data.
REQ-007 SHALL have port io_out_ready, input, 1: downstream accepts a beat.
REQ-008 SHALL have port io_out_valid, output, 1: io_out carries a beat.
REQ-009 SHALL have port io_out, output, WIDTH: data of the granted requester.
REQ-010 SHALL have port io_path, output, 5: registered one-hot grant, all-zero when idle.
REQ-011 SHALL have port io_ack, output, 5: one-cycle pulse on bit i when requester i+1's beat is accepted.
REQ-012 SHALL have port io_timeout, output, 1: one-cycle pulse on forced grant release.

Function
REQ-013 SHALL implement FSM states IDLE and BUSY.
REQ-014 SHALL in IDLE, when io_req is nonzero, register a one-hot io_path chosen round-robin starting at the index after the last released grant, zero the beat counter, and enter BUSY on the next edge.
REQ-015 SHALL in IDLE with io_req==0 hold io_path==0 and remain in IDLE.
REQ-016 SHALL drive io_out as the AND-OR one-hot select of io_in1..io_in5 by io_path, combinationally, so io_out==0 when io_path==0.
REQ-017 SHALL drive io_out_valid = (state==BUSY) AND io_req bit selected by io_path.
REQ-018 SHALL count a beat when io_out_valid and io_out_ready are both 1; io_ack for the granted bit is asserted combinationally in that same cycle.
REQ-019 SHALL release the grant (io_path to 0, record granted index as last, return to IDLE) on the edge after the MAX_BURST-th beat.
REQ-020 SHALL release the grant when in BUSY the granted io_req bit is 0, without a beat.
REQ-021 SHALL spend exactly one IDLE cycle between consecutive grants, so arbitration latency is 1 cycle from IDLE request to io_out_valid.
REQ-022 SHALL ignore changes of non-granted io_req bits while in BUSY.
REQ-023 SHALL wrap the rotation pointer from requester 5 to requester 1.
REQ-024 SHALL never assert more than one io_path bit or one io_ack bit.

Reset
REQ-025 SHALL on reset==0 set state IDLE, io_path 0, beat counter 0, stall counter 0, last pointer 5 (requester 1 first), giving io_out_valid 0, io_out 0, io_ack 0, io_timeout 0.
REQ-026 SHALL, if reset asserts during BUSY, abandon the burst with no io_ack or io_timeout pulse in the following cycle.

Configuration
REQ-027 SHALL, with macro ARB_HOLD_TIMEOUT_EN defined, count consecutive BUSY cycles with io_out_valid==1 and io_out_ready==0; counter clears on any beat.
REQ-028 SHALL, with ARB_HOLD_TIMEOUT_EN defined, force grant release when that count reaches 15, pulse io_timeout for that one cycle, and advance the rotation past the stalled requester.
REQ-029 SHALL, with ARB_HOLD_TIMEOUT_EN undefined, omit the stall counter, tie io_timeout to 0, and hold grants indefinitely under backpressure.

Verification
REQ-030 SHALL cover: reset, then io_req=5'b00100, io_in3=8'hA5, ready=1 -> io_path=5'b00100 one cycle later, io_out=8'hA5, 4 io_ack pulses on bit 2, then io_path=0.
REQ-031 SHALL cover: io_req=5'b11111 held, ready=1, MAX_BURST=4 -> grants rotate 1,2,3,4,5,1, each 4 beats separated by one idle cycle.
REQ-032 SHALL cover: requester 2 granted, io_req[1] dropped after 2 beats -> release on the next edge, no third ack, next grant goes to the next requester.
REQ-033 SHALL cover: ready toggling 1,0,0,1 during a burst -> beats only on ready cycles, io_out stable while stalled, io_ack count equals 4.
REQ-034 SHALL cover, with ARB_HOLD_TIMEOUT_EN defined: granted requester, ready=0 for 15 cycles -> io_timeout pulse, io_path=0; without the macro -> grant held and io_timeout=0 after 20 cycles.
REQ-035 SHALL cover: reset asserted mid-burst -> all outputs 0 on the next cycle, first grant after reset goes to requester 1 when io_req=5'b10001.
